// File: rtl/channel_in_group_acc.sv
// Accumulates per-lane adder-tree partial sums across channel-in groups and
// emits one full convolution sum per output pixel, then a done pulse.
module channel_in_group_acc #(
    parameter int LANES = 8,
    parameter int IN_W  = 32,
    parameter int ACC_W = IN_W + 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       group_num,
    input  logic [CNT_W-1:0]       pixel_num,
    input  logic                   data_in_valid,
    input  logic [LANES*IN_W-1:0]  data_in,
    output logic                   data_out_valid,
    output logic [LANES*ACC_W-1:0] data_out,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     grp_max_q, grp_max_d;
    logic [CNT_W-1:0]     pix_max_q, pix_max_d;
    logic [CNT_W-1:0]     group_cnt_q, group_cnt_d;
    logic [CNT_W-1:0]     pixel_cnt_q, pixel_cnt_d;
    logic [LANES*ACC_W-1:0] acc_q, acc_d;
    logic [LANES*ACC_W-1:0] data_out_q, data_out_d;
    logic                 data_out_valid_q, data_out_valid_d;
    logic [LANES*ACC_W-1:0] sum;

    function automatic logic [ACC_W-1:0] sext(input logic [IN_W-1:0] x);
        return {{(ACC_W-IN_W){x[IN_W-1]}}, x};
    endfunction

    // The first group of a pixel overwrites the accumulator, so no clear cycle is needed.
    always_comb begin
        sum = '0;
        for (int p = 0; p < LANES; p++) begin
            if (group_cnt_q == '0)
                sum[p*ACC_W +: ACC_W] = sext(data_in[p*IN_W +: IN_W]);
            else
                sum[p*ACC_W +: ACC_W] = acc_q[p*ACC_W +: ACC_W] + sext(data_in[p*IN_W +: IN_W]);
        end
    end

    always_comb begin
        state_d          = state_q;
        grp_max_d        = grp_max_q;
        pix_max_d        = pix_max_q;
        group_cnt_d      = group_cnt_q;
        pixel_cnt_d      = pixel_cnt_q;
        acc_d            = acc_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    grp_max_d   = (group_num == '0) ? '0 : group_num - CNT_W'(1);
                    pix_max_d   = (pixel_num == '0) ? '0 : pixel_num - CNT_W'(1);
                    group_cnt_d = '0;
                    pixel_cnt_d = '0;
                    state_d     = S_ACC;
                end
            end
            S_ACC: begin
                if (data_in_valid) begin
                    acc_d = sum;
                    if (group_cnt_q == grp_max_q) begin
                        data_out_d       = sum;
                        data_out_valid_d = 1'b1;
                        group_cnt_d      = '0;
                        if (pixel_cnt_q == pix_max_q) begin
                            pixel_cnt_d = '0;
                            state_d     = S_DONE;
                        end else begin
                            pixel_cnt_d = pixel_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        group_cnt_d = group_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            grp_max_q        <= '0;
            pix_max_q        <= '0;
            group_cnt_q      <= '0;
            pixel_cnt_q      <= '0;
            acc_q            <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            grp_max_q        <= grp_max_d;
            pix_max_q        <= pix_max_d;
            group_cnt_q      <= group_cnt_d;
            pixel_cnt_q      <= pixel_cnt_d;
            acc_q            <= acc_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
        end
    end

    // done coincides with the final data_out_valid because DONE follows the last beat.
    assign data_out_valid = data_out_valid_q;
    assign data_out       = data_out_q;
    assign busy           = (state_q == S_ACC);
    assign done           = (state_q == S_DONE);

endmodule

// File: tb/tb_channel_in_group_acc.sv
// Directed bench for channel_in_group_acc: expected pixel sums are queued
// before the final beat of each pixel and checked by an output monitor.
module tb_channel_in_group_acc;

    localparam int LANES = 8;
    localparam int IN_W  = 32;
    localparam int ACC_W = 40;
    localparam int CNT_W = 16;
    localparam int OW    = LANES * ACC_W;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic [CNT_W-1:0]      group_num;
    logic [CNT_W-1:0]      pixel_num;
    logic                  data_in_valid;
    logic [LANES*IN_W-1:0] data_in;
    logic                  data_out_valid;
    logic [OW-1:0]         data_out;
    logic                  busy;
    logic                  done;

    // bit OW is the expected done flag, bits OW-1:0 the expected lane sums
    logic [OW:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    channel_in_group_acc #(
        .LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .group_num(group_num), .pixel_num(pixel_num),
        .data_in_valid(data_in_valid), .data_in(data_in),
        .data_out_valid(data_out_valid), .data_out(data_out),
        .busy(busy), .done(done)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus helpers
    function automatic logic [LANES*IN_W-1:0] in_all(input longint v);
        logic [63:0] t;
        logic [LANES*IN_W-1:0] r;
        t = v;
        for (int p = 0; p < LANES; p++) r[p*IN_W +: IN_W] = t[IN_W-1:0];
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_all(input longint v);
        logic [63:0] t;
        logic [OW-1:0] r;
        t = v;
        for (int p = 0; p < LANES; p++) r[p*ACC_W +: ACC_W] = t[ACC_W-1:0];
        return r;
    endfunction

    function automatic logic [LANES*IN_W-1:0] in_scaled(input int k);
        logic [LANES*IN_W-1:0] r;
        for (int p = 0; p < LANES; p++) r[p*IN_W +: IN_W] = IN_W'((p + 1) * k);
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_scaled(input int k);
        logic [OW-1:0] r;
        for (int p = 0; p < LANES; p++) r[p*ACC_W +: ACC_W] = ACC_W'((p + 1) * k);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_beat(input logic [LANES*IN_W-1:0] d);
        data_in       = d;
        data_in_valid = 1'b1;
        cyc();
        data_in_valid = 1'b0;
    endtask

    task automatic start_layer(input int g, input int p);
        group_num = CNT_W'(g);
        pixel_num = CNT_W'(p);
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic push_exp(input logic [OW-1:0] d, input logic dn);
        exp_q.push_back({dn, d});
    endtask

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (done && !data_out_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_without_valid: done=1 data_out_valid=0, expected done only with valid");
            end
            if (data_out_valid) begin
                logic [OW:0] e;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_valid: got data_out=%h, expected no output", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e[OW-1:0] || done !== e[OW]) begin
                        n_fail++;
                        $display("FAIL pixel_sum: got data_out=%h done=%b, expected %h done=%b",
                                 data_out, done, e[OW-1:0], e[OW]);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; group_num = '0; pixel_num = '0;
        data_in_valid = 1'b0; data_in = '0;
        idle(3);
        check("reset_valid", longint'(data_out_valid), 0);
        check("reset_data",  longint'(data_out != '0), 0);
        check("reset_busy",  longint'(busy), 0);
        check("reset_done",  longint'(done), 0);
        rst_n = 1'b1;
        idle(2);

        // basic: 10 + 20 - 5 = 25
        start_layer(3, 1);
        check("busy_after_start", longint'(busy), 1);
        send_beat(in_all(10));
        send_beat(in_all(20));
        push_exp(exp_all(25), 1'b1);
        send_beat(in_all(-5));
        check("basic_valid_latency", longint'(data_out_valid), 1);
        check("basic_done", longint'(done), 1);
        idle(2);
        check("basic_busy_low", longint'(busy), 0);
        check("basic_data_hold", longint'(data_out[ACC_W-1:0]), 25);

        // single group, back-to-back pixels
        start_layer(1, 4);
        for (int k = 1; k <= 4; k++) begin
            push_exp(exp_scaled(k), k == 4);
            send_beat(in_scaled(k));
            check("single_no_bubble", longint'(data_out_valid), 1);
        end
        idle(2);

        // gaps and sign extension: -2^31 + -1
        start_layer(2, 2);
        for (int px = 0; px < 2; px++) begin
            send_beat(in_all(-64'sd2147483648));
            idle(3);
            push_exp(exp_all(-64'sd2147483649), px == 1);
            send_beat(in_all(-1));
        end
        idle(2);

        // zero parameters behave as 1/1
        start_layer(0, 0);
        push_exp(exp_all(7), 1'b1);
        send_beat(in_all(7));
        idle(2);

        // beats while idle are ignored
        send_beat(in_all(99));
        send_beat(in_all(99));
        idle(2);
        check("idle_beats_busy", longint'(busy), 0);

        // start mid-layer ignored: 1 + 2 + 3
        start_layer(3, 1);
        send_beat(in_all(1));
        start_layer(1, 1);
        send_beat(in_all(2));
        push_exp(exp_all(6), 1'b1);
        send_beat(in_all(3));
        idle(2);

        // start together with a beat: that beat is ignored
        group_num = CNT_W'(1); pixel_num = CNT_W'(1);
        start = 1'b1; data_in = in_all(50); data_in_valid = 1'b1;
        cyc();
        start = 1'b0; data_in_valid = 1'b0;
        push_exp(exp_all(4), 1'b1);
        send_beat(in_all(4));
        idle(2);

        // asynchronous reset mid-layer
        start_layer(3, 1);
        send_beat(in_all(5));
        #2 rst_n = 1'b0;
        #1;
        check("midreset_valid", longint'(data_out_valid), 0);
        check("midreset_data",  longint'(data_out != '0), 0);
        check("midreset_busy",  longint'(busy), 0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        start_layer(3, 1);
        send_beat(in_all(1));
        send_beat(in_all(2));
        push_exp(exp_all(6), 1'b1);
        send_beat(in_all(3));
        idle(2);

        // maximum depth: 256 * (2^31 - 1)
        start_layer(256, 1);
        for (int k = 0; k < 255; k++) send_beat(in_all(64'sh7FFFFFFF));
        push_exp(exp_all(64'sd549755813632), 1'b1);
        send_beat(in_all(64'sh7FFFFFFF));
        idle(3);

        check("scoreboard_drained", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
